// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported backing memory between the fetch port (I) and the
//   MEM-stage load/store port (D). One transaction is in flight at a time.
//   The data side wins arbitration unless a fetch has waited through
//   STARVE_MAX consecutive data grants, in which case the fetch is forced.
//   A branch redirect (flush_F) drops the outstanding fetch response.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   i_req/i_addr             fetch read request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata   fetch grant and response
//   flush_F                  drop the outstanding fetch response
//   d_req/d_we/d_byt/d_addr/d_wdata   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   data grant and response (store: d_rdata = 0)
//   m_req/m_we/m_byt/m_addr/m_wdata   one-cycle memory command
//   m_rvalid/m_rdata         memory response, >= 1 cycle after m_req
//   stall_F/stall_MEM        pipeline stalls for the waiting stage
//   err                      sticky: memory response seen while idle
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [XLEN-1:0]      i_rdata,
  input  logic                 flush_F,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic                 d_byt,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 m_req,
  output logic                 m_we,
  output logic                 m_byt,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [XLEN-1:0]      m_wdata,
  input  logic                 m_rvalid,
  input  logic [XLEN-1:0]      m_rdata,
  output logic                 stall_F,
  output logic                 stall_MEM,
  output logic                 err
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] I_WAIT = 2'b01;
  localparam logic [1:0] D_WAIT = 2'b10;

  localparam int unsigned CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          drop;
  logic          d_we_q;   // store/load kind of the D transaction in flight
  logic          pick_i;

  // Outputs are forced to zero while rst is low, even though the arbitration
  // itself is combinational from the request inputs.
  always_comb begin
    i_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_byt     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    stall_F   = 1'b0;
    stall_MEM = 1'b0;
    state_nxt = state;
    pick_i    = i_req & (~d_req | (starve_cnt == STARVE_LIM));
    if (rst) begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            i_gnt     = 1'b1;
            m_req     = 1'b1;
            m_addr    = i_addr;
            state_nxt = I_WAIT;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            m_req     = 1'b1;
            m_we      = d_we;
            m_byt     = d_byt;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            state_nxt = D_WAIT;
          end
        end
        I_WAIT: begin
          if (m_rvalid) begin
            i_rvalid  = ~(drop | flush_F);
            i_rdata   = i_rvalid ? m_rdata : '0;
            state_nxt = IDLE;
          end
        end
        D_WAIT: begin
          if (m_rvalid) begin
            d_rvalid  = 1'b1;
            d_rdata   = d_we_q ? '0 : m_rdata;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
      stall_F   = i_req & ~i_gnt;
      stall_MEM = (d_req & ~d_gnt) | ((state == D_WAIT) & ~d_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      err        <= 1'b0;
      d_we_q     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (!i_req || i_gnt)
        starve_cnt <= '0;
      else if (d_gnt && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + CW'(1);

      // A flush that arrives before the fetch data is remembered until the
      // response retires; a flush coinciding with the data drops it directly.
      if (state == I_WAIT)
        drop <= m_rvalid ? 1'b0 : (drop | flush_F);
      else
        drop <= 1'b0;

      if ((state == IDLE) && m_rvalid)
        err <= 1'b1;

      if (d_gnt)
        d_we_q <= d_we;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed stimulus for mem_port_arbiter against a behavioural memory with
//   programmable latency. Issuing tasks push expected commands/responses into
//   queues; a monitor branch pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AB   = 5;
  localparam byte GD = 8'h44;  // 'D'
  localparam byte GI = 8'h49;  // 'I'

  typedef struct packed {
    logic          we;
    logic          byt;
    logic [AB-1:0] addr;
    logic [31:0]   wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  logic i_req, flush_F, d_req, d_we, d_byt;
  logic [AB-1:0] i_addr, d_addr;
  logic [XLEN-1:0] d_wdata;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [XLEN-1:0] i_rdata, d_rdata;
  logic m_req, m_we, m_byt, m_rvalid;
  logic [AB-1:0] m_addr;
  logic [XLEN-1:0] m_wdata, m_rdata;
  logic stall_F, stall_MEM, err;

  int checks = 0;
  int errors = 0;

  cmd_t        exp_icmd[$];
  cmd_t        exp_dcmd[$];
  logic [31:0] exp_irsp[$];
  logic [31:0] exp_drsp[$];
  byte         gnt_log[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_BITS(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .flush_F(flush_F),
    .d_req(d_req), .d_we(d_we), .d_byt(d_byt), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_byt(m_byt), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .stall_F(stall_F), .stall_MEM(stall_MEM), .err(err)
  );

  // Behavioural memory: contents restored to a known pattern on reset,
  // in-flight command cancelled by reset. Writes answer with junk read data.
  logic [XLEN-1:0] mem [32];
  int unsigned     mem_lat = 1;
  int unsigned     mem_cnt;
  logic            mem_pend, mem_rv, spur;
  logic [31:0]     mem_rd, mem_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 32; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
      mem_pend <= 1'b0;
      mem_rv   <= 1'b0;
      mem_rd   <= '0;
      mem_hold <= '0;
      mem_cnt  <= 0;
    end else begin
      mem_rv <= 1'b0;
      if (m_req) begin
        if (m_we) begin
          if (m_byt) mem[m_addr][7:0] <= m_wdata[7:0];
          else       mem[m_addr]      <= m_wdata;
          mem_hold <= 32'hFFFF_FFFF;
        end else begin
          mem_hold <= mem[m_addr];
        end
        if (mem_lat <= 1) begin
          mem_rv <= 1'b1;
          mem_rd <= m_we ? 32'hFFFF_FFFF : mem[m_addr];
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= mem_lat - 1;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 1) begin
          mem_rv   <= 1'b1;
          mem_rd   <= mem_hold;
          mem_pend <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  assign m_rvalid = mem_rv | spur;
  assign m_rdata  = spur ? 32'h5555_5555 : mem_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required nothing (t=%0t)", name, act, $time);
  endtask

  function automatic cmd_t mk(input logic we, input logic byt, input logic [AB-1:0] a,
                              input logic [31:0] wd);
    cmd_t c;
    c.we = we; c.byt = byt; c.addr = a; c.wdata = wd;
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_byt,
                         stall_F, stall_MEM, err}, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_m_addr_wdata"}, {m_addr, m_wdata}, 0);
  endtask

  // Called just after a rising edge; returns just after the edge that ends
  // the grant cycle, with the request dropped.
  task automatic i_issue(input logic [AB-1:0] a, input logic [31:0] exp, input bit want_rsp);
    int n = 0;
    i_addr = a;
    i_req  = 1'b1;
    exp_icmd.push_back(mk(1'b0, 1'b0, a, 32'h0));
    if (want_rsp) exp_irsp.push_back(exp);
    @(negedge clk);
    while (!i_gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!i_gnt) chk("i_gnt_timeout", i_gnt, 1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic d_issue(input logic we, input logic byt, input logic [AB-1:0] a,
                         input logic [31:0] wd, input logic [31:0] exp, input bit want_rsp);
    int n = 0;
    d_we    = we;
    d_byt   = byt;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    exp_dcmd.push_back(mk(we, byt, a, wd));
    if (want_rsp) exp_drsp.push_back(exp);
    @(negedge clk);
    while (!d_gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!d_gnt) chk("d_gnt_timeout", d_gnt, 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic monitor();
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (m_req) begin
          chk("gnt_count", 64'(i_gnt) + 64'(d_gnt), 1);
          if (d_gnt) begin
            gnt_log.push_back(GD);
            if (exp_dcmd.size() == 0) fail("d_cmd_unexpected", {m_we, m_byt, m_addr, m_wdata});
            else begin
              e = exp_dcmd.pop_front();
              chk("d_cmd", {m_we, m_byt, m_addr, m_wdata}, e);
            end
            if (i_req) chk("stall_F_during_D", stall_F, 1);
          end
          if (i_gnt) begin
            gnt_log.push_back(GI);
            if (exp_icmd.size() == 0) fail("i_cmd_unexpected", {m_we, m_byt, m_addr, m_wdata});
            else begin
              e = exp_icmd.pop_front();
              chk("i_cmd", {m_we, m_byt, m_addr, m_wdata}, e);
            end
          end
        end else if (i_gnt || d_gnt) begin
          fail("gnt_without_m_req", {i_gnt, d_gnt});
        end
        if ((i_rvalid || d_rvalid) && (i_gnt || d_gnt))
          fail("rsp_with_gnt", {i_rvalid, d_rvalid, i_gnt, d_gnt});
        if (i_rvalid) begin
          if (exp_irsp.size() == 0) fail("i_rsp_unexpected", i_rdata);
          else chk("i_rdata", i_rdata, exp_irsp.pop_front());
        end else if (m_rvalid) begin
          chk("i_rdata_idle", i_rdata, 0);
        end
        if (d_rvalid) begin
          if (exp_drsp.size() == 0) fail("d_rsp_unexpected", d_rdata);
          else chk("d_rdata", d_rdata, exp_drsp.pop_front());
        end else if (m_rvalid) begin
          chk("d_rdata_idle", d_rdata, 0);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte exp_order[5];
    exp_order = '{GD, GD, GD, GD, GI};
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; flush_F = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_byt = 1'b0; d_addr = '0; d_wdata = '0;
    spur = 1'b0;
    fork monitor(); join_none

    // 1: both request during reset; data side wins after release
    mem_lat = 1;
    fork
      i_issue(5'd1, 32'hC0DE_0001, 1'b1);
      d_issue(1'b0, 1'b0, 5'd4, 32'h0, 32'hC0DE_0004, 1'b1);
      begin
        @(negedge clk); chk_zero("t1_rst_a");
        @(negedge clk); chk_zero("t1_rst_b");
        @(posedge clk); #1; rst = 1'b1;
      end
    join
    cycles(3);
    chk("t1_first_gnt",  (gnt_log.size() > 0) ? gnt_log[0] : 8'h0, GD);
    chk("t1_second_gnt", (gnt_log.size() > 1) ? gnt_log[1] : 8'h0, GI);
    gnt_log.delete();

    // 2: starvation forces the fetch after four data grants
    fork
      i_issue(5'd10, 32'hC0DE_000A, 1'b1);
      begin
        d_issue(1'b0, 1'b0, 5'd11, 32'h0, 32'hC0DE_000B, 1'b1);
        d_issue(1'b0, 1'b0, 5'd12, 32'h0, 32'hC0DE_000C, 1'b1);
        d_issue(1'b0, 1'b0, 5'd13, 32'h0, 32'hC0DE_000D, 1'b1);
        d_issue(1'b0, 1'b0, 5'd14, 32'h0, 32'hC0DE_000E, 1'b1);
        d_issue(1'b0, 1'b0, 5'd15, 32'h0, 32'hC0DE_000F, 1'b1);
      end
    join
    cycles(3);
    for (int i = 0; i < 5; i++)
      chk("t2_gnt_order", (gnt_log.size() > i) ? gnt_log[i] : 8'h0, exp_order[i]);
    gnt_log.delete();

    // 3: flush before the data (latency 2), flush with the data (latency 1),
    //    flush while a data transaction is outstanding
    mem_lat = 2;
    i_issue(5'd5, 32'h0, 1'b0);
    flush_F = 1'b1;
    cycles(1);
    flush_F = 1'b0;
    cycles(3);
    i_issue(5'd6, 32'hC0DE_0006, 1'b1);
    cycles(3);
    mem_lat = 1;
    i_issue(5'd8, 32'h0, 1'b0);
    flush_F = 1'b1;
    cycles(1);
    flush_F = 1'b0;
    cycles(1);
    i_issue(5'd8, 32'hC0DE_0008, 1'b1);
    cycles(2);
    flush_F = 1'b1;
    d_issue(1'b0, 1'b0, 5'd1, 32'h0, 32'hC0DE_0001, 1'b1);
    cycles(2);
    flush_F = 1'b0;

    // 4: word store, load back, byte store, load back
    mem_lat = 2;
    d_issue(1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b1);
    @(negedge clk);
    chk("t4_stall_mem_wait", stall_MEM, 1);
    cycles(3);
    mem_lat = 1;
    d_issue(1'b0, 1'b0, 5'd3, 32'h0, 32'hDEAD_BEEF, 1'b1);
    d_issue(1'b1, 1'b1, 5'd7, 32'h1234_5677, 32'h0, 1'b1);
    d_issue(1'b0, 1'b0, 5'd7, 32'h0, 32'hC0DE_0077, 1'b1);
    cycles(3);

    // 5: spurious memory response while idle
    @(negedge clk);
    chk("t5_err_before", err, 0);
    cycles(1);
    spur = 1'b1;
    cycles(1);
    spur = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err, 1);
    cycles(1);
    i_issue(5'd2, 32'hC0DE_0002, 1'b1);
    cycles(3);
    @(negedge clk);
    chk("t5_err_sticky", err, 1);
    cycles(1);
    rst = 1'b0;
    #1;
    chk_zero("t5_rst");
    cycles(1);
    rst = 1'b1;
    cycles(1);

    // 6: reset while a load is outstanding; the pending fetch then proceeds
    mem_lat = 3;
    fork
      i_issue(5'd9, 32'hC0DE_0009, 1'b1);
      begin
        d_issue(1'b0, 1'b0, 5'd2, 32'h0, 32'h0, 1'b0);
        chk("t6_starve_before", dut.starve_cnt, 1);
        rst = 1'b0;
        #1;
        chk_zero("t6_rst");
        chk("t6_state_idle", dut.state, 0);
        chk("t6_starve_cleared", dut.starve_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
      end
    join
    cycles(6);

    chk("end_icmd_left", exp_icmd.size(), 0);
    chk("end_dcmd_left", exp_dcmd.size(), 0);
    chk("end_irsp_left", exp_irsp.size(), 0);
    chk("end_drsp_left", exp_drsp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
